// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state encoding and default timeout for the APB master arbiter.
package apb_arb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
   localparam int unsigned TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/apb_bus.sv
// APB_BUS: APB signal bundle with master and slave views.
interface APB_BUS #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pwrite;
   logic                  psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;
   modport Master (output paddr, pwdata, pwrite, psel, penable, input prdata, pready, pslverr);
   modport Slave  (input paddr, pwdata, pwrite, psel, penable, output prdata, pready, pslverr);
endinterface

// File: rtl/rr_arb_2.sv
// rr_arb_2: two-way round-robin picker; on contention the requester not granted last wins.
module rr_arb_2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       advance,
   output logic [1:0] gnt
);
   assign gnt = !advance ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between two requesters with round-robin
// arbitration, wait-state support and an ACCESS-phase timeout.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [1:0]                     req_i,
   input  logic [1:0][APB_ADDR_WIDTH-1:0] addr_i,
   input  logic [1:0][APB_DATA_WIDTH-1:0] wdata_i,
   input  logic [1:0]                     we_i,
   output logic [1:0]                     gnt_o,
   output logic [1:0]                     rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]      rdata_o,
   output logic                           err_o,
   APB_BUS.Master                         apb_master
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e                    state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      we_q, we_d;
   logic                      last_q, last_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [1:0]                rvalid_q, rvalid_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [1:0]                gnt;
   logic                      win;

   rr_arb_2 u_rr (
      .req     (req_i),
      .last    (last_q),
      .advance (state_q == IDLE),
      .gnt     (gnt)
   );

   assign win = gnt[1];

   // last_q doubles as the owner of the transfer in flight
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      rvalid_d = 2'b00;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (|gnt) begin
            state_d = SETUP;
            addr_d  = addr_i[win];
            wdata_d = wdata_i[win];
            we_d    = we_i[win];
            last_d  = win;
            cnt_d   = '0;
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (apb_master.pready) begin
               state_d  = IDLE;
               rvalid_d = last_q ? 2'b10 : 2'b01;
               rdata_d  = apb_master.prdata;
               err_d    = apb_master.pslverr;
            end else if (cnt_q >= TO_LAST) begin
               state_d  = IDLE;
               rvalid_d = last_q ? 2'b10 : 2'b01;
               rdata_d  = '0;
               err_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // bus strobes decode straight from the state so reset drops them without waiting for a clock
   assign apb_master.psel    = (state_q != IDLE);
   assign apb_master.penable = (state_q == ACCESS);
   assign apb_master.paddr   = addr_q;
   assign apb_master.pwdata  = wdata_q;
   assign apb_master.pwrite  = we_q;
   assign gnt_o    = gnt;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of arbitration, APB phasing, wait states,
// slave error, timeout and mid-transfer reset.
module tb_apb_master_arbiter;
   logic             clk = 1'b0;
   logic             rst_ni;
   logic [1:0]       req, we, gnt, rvalid;
   logic [1:0][31:0] addr, wdata;
   logic [31:0]      rdata;
   logic             err;
   int               vectors = 0;
   int               miscompares = 0;

   APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_master_arbiter #(
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .req_i      (req),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .we_i       (we),
      .gnt_o      (gnt),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .err_o      (err),
      .apb_master (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      #3;
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      vectors++; if (rvalid !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
      vectors++; if (rdata !== 32'h0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_rdata_err: got %h/%b want 0/0", rdata, err); end
      vectors++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b want 000", {bus.psel, bus.penable, bus.pwrite}); end
      vectors++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got %h/%h want 0/0", bus.paddr, bus.pwdata); end
      @(negedge clk); rst_ni = 1'b1;
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      req = 2'b11; we = 2'b00; addr[0] = 32'h1A10_0000; addr[1] = 32'h1A10_0100; bus.pready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL contention_gnt%0d: got %b want %b", k, gnt, exp_g); end
         @(negedge clk); #1;
         vectors++; if (gnt !== 2'b00 || bus.psel !== 1'b1 || bus.penable !== 1'b0) begin miscompares++; $display("FAIL contention_setup%0d: got gnt %b psel %b penable %b want 00/1/0", k, gnt, bus.psel, bus.penable); end
         vectors++; if (bus.paddr !== addr[exp_g[1]]) begin miscompares++; $display("FAIL contention_paddr%0d: got %h want %h", k, bus.paddr, addr[exp_g[1]]); end
         @(negedge clk); bus.prdata = 32'hA0 + k;
         @(negedge clk);
         if (k == 3) req = 2'b00;
         #1;
         vectors++; if (rvalid !== exp_g || rdata !== 32'hA0 + k) begin miscompares++; $display("FAIL contention_rvalid%0d: got %b/%h want %b/%h", k, rvalid, rdata, exp_g, 32'hA0 + k); end
      end
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL contention_idle_gnt: got %b want 00", gnt); end
      bus.pready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      req = 2'b01; we = 2'b00; addr[0] = 32'h1A10_1000; #1;
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL read_gnt: got %b want 01", gnt); end
      @(negedge clk); req = 2'b00; bus.pready = 1'b1; bus.prdata = 32'hDEAD_BEEF; #1;
      vectors++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100 || bus.paddr !== 32'h1A10_1000) begin miscompares++; $display("FAIL read_setup: got %b %h want 100 1a101000", {bus.psel, bus.penable, bus.pwrite}, bus.paddr); end
      @(negedge clk); #1;
      vectors++; if ({bus.psel, bus.penable} !== 2'b11 || rvalid !== 2'b00) begin miscompares++; $display("FAIL read_access: got %b rvalid %b want 11 00", {bus.psel, bus.penable}, rvalid); end
      @(negedge clk); bus.pready = 1'b0; #1;
      vectors++; if (rvalid !== 2'b01 || rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin miscompares++; $display("FAIL read_rvalid: got %b %h %b want 01 deadbeef 0", rvalid, rdata, err); end
      vectors++; if ({bus.psel, bus.penable} !== 2'b00) begin miscompares++; $display("FAIL read_idle_strobes: got %b want 00", {bus.psel, bus.penable}); end
      @(negedge clk); #1;
      vectors++; if (rvalid !== 2'b00) begin miscompares++; $display("FAIL read_pulse: got %b want 00", rvalid); end
   endtask

   task automatic test_wait_states();
      req = 2'b10; we = 2'b10; addr[1] = 32'h1A10_3000; wdata[1] = 32'h1234_5678; #1;
      vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL wait_gnt: got %b want 10", gnt); end
      @(negedge clk); req = 2'b00; #1;
      vectors++; if (bus.pwrite !== 1'b1 || bus.penable !== 1'b0) begin miscompares++; $display("FAIL wait_setup: got pwrite %b penable %b want 1 0", bus.pwrite, bus.penable); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); bus.pready = (i == 5); #1;
         vectors++; if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 32'h1A10_3000 || bus.pwdata !== 32'h1234_5678 || rvalid !== 2'b00) begin miscompares++; $display("FAIL wait_access%0d: got %b %h %h rvalid %b want 11 1a103000 12345678 00", i, {bus.psel, bus.penable}, bus.paddr, bus.pwdata, rvalid); end
      end
      @(negedge clk); bus.pready = 1'b0; #1;
      vectors++; if (rvalid !== 2'b10 || err !== 1'b0) begin miscompares++; $display("FAIL wait_rvalid: got %b err %b want 10 0", rvalid, err); end
      @(negedge clk);
   endtask

   task automatic test_slave_error();
      req = 2'b01; we = 2'b00;
      @(negedge clk); req = 2'b00; bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'h0BAD_0BAD;
      @(negedge clk);
      @(negedge clk); bus.pready = 1'b0; bus.pslverr = 1'b0; #1;
      vectors++; if (rvalid !== 2'b01 || err !== 1'b1) begin miscompares++; $display("FAIL slverr_rvalid: got %b err %b want 01 1", rvalid, err); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      req = 2'b01; we = 2'b00; bus.prdata = 32'hFFFF_FFFF;
      @(negedge clk); req = 2'b00;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         vectors++; if ({bus.psel, bus.penable} !== 2'b11 || rvalid !== 2'b00) begin miscompares++; $display("FAIL timeout_access%0d: got %b rvalid %b want 11 00", i, {bus.psel, bus.penable}, rvalid); end
      end
      @(negedge clk); #1;
      vectors++; if (rvalid !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin miscompares++; $display("FAIL timeout_rvalid: got %b %b %h want 01 1 0", rvalid, err, rdata); end
      // pready on the eighth ACCESS cycle wins over the timeout
      req = 2'b10; @(negedge clk); req = 2'b00; bus.prdata = 32'h55AA_55AA;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); bus.pready = (i == 7);
      end
      @(negedge clk); bus.pready = 1'b0; #1;
      vectors++; if (rvalid !== 2'b10 || err !== 1'b0 || rdata !== 32'h55AA_55AA) begin miscompares++; $display("FAIL timeout_edge: got %b %b %h want 10 0 55aa55aa", rvalid, err, rdata); end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      req = 2'b10; we = 2'b10;
      @(negedge clk); req = 2'b00;
      @(negedge clk); #1;
      vectors++; if ({bus.psel, bus.penable} !== 2'b11) begin miscompares++; $display("FAIL midrst_access: got %b want 11", {bus.psel, bus.penable}); end
      #1 rst_ni = 1'b0; #1;
      vectors++; if ({bus.psel, bus.penable} !== 2'b00) begin miscompares++; $display("FAIL midrst_async: got %b want 00", {bus.psel, bus.penable}); end
      bus.pready = 1'b1;
      @(negedge clk); #1;
      vectors++; if (rvalid !== 2'b00) begin miscompares++; $display("FAIL midrst_rvalid: got %b want 00", rvalid); end
      rst_ni = 1'b1; bus.pready = 1'b0; req = 2'b11; we = 2'b00; #1;
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_first_gnt: got %b want 01", gnt); end
      @(negedge clk); req = 2'b10; bus.pready = 1'b1; bus.prdata = 32'hCAFE_F00D; #1;
      vectors++; if (rvalid !== 2'b00) begin miscompares++; $display("FAIL midrst_no_stale: got %b want 00", rvalid); end
      @(negedge clk);
      @(negedge clk); req = 2'b00; bus.pready = 1'b0; #1;
      vectors++; if (rvalid !== 2'b01 || rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL midrst_after: got %b %h want 01 cafef00d", rvalid, rdata); end
   endtask

   initial begin
      rst_ni = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
      bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
      test_reset();
      test_contention();
      test_single_read();
      test_wait_states();
      test_slave_error();
      test_timeout();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
